// File: rtl/ram_if_pkg.sv
// rtl/ram_if_pkg.sv - shared types and default widths for the RAM access controller
// Contents:
//   DEF_ADDR_W / DEF_DATA_W : default RAM geometry (64 x 8)
//   ram_ctrl_state_t        : controller state encoding
//   ram_req_t               : one request (we, addr, wdata) at default widths
package ram_if_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } ram_ctrl_state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - request/response channel bundle for ram_access_ctrl
// Signals:
//   req_valid/req_ready : request handshake
//   req_we/req_addr/req_wdata : request payload, sampled on the handshake edge
//   rsp_valid/rsp_ready : read-response handshake
//   rsp_rdata : read data, stable while rsp_valid is high
// Modports: master = requester side, slave = controller side.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = ram_if_pkg::DEF_ADDR_W,
    parameter int DATA_W = ram_if_pkg::DEF_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/single_port_RAM.sv
// rtl/single_port_RAM.sv - single-port RAM, synchronous write, read pipelined by LAT cycles
// Ports:
//   clk     : rising-edge clock
//   we      : write enable, data_in stored at addr on the rising edge
//   addr    : word address for both read and write
//   data_in : write data
//   q       : read data, mem[addr] delayed by LAT edges (LAT = 0 gives a combinational read)
module single_port_RAM #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data_in;
        end
    end

    generate
        if (LAT == 0) begin : g_comb
            assign q = mem[addr];
        end else begin : g_pipe
            logic [DATA_W-1:0] pipe [LAT];

            always_ff @(posedge clk) begin
                pipe[0] <= mem[addr];
                for (int i = 1; i < LAT; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - initiator-side controller for a single-port RAM
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : request channel in, read-response channel out
//   ram_data_in, ram_addr, ram_we : RAM port, driven only by this block
//   ram_q          : RAM read data, valid RD_LAT cycles after ram_addr
//   busy           : high whenever the controller is not idle
// Every output comes straight from a flop; the comb process computes next
// values for all of them so req_ready/busy always agree with the state.
module ram_access_ctrl
    import ram_if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    ram_access_ctrl_if.slave  bus,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    // RD_LAT is limited to 0..3, so a 2-bit counter covers it
    localparam logic [1:0] LAT_CNT = 2'(RD_LAT);

    ram_ctrl_state_t   state_q, state_n;
    logic [1:0]        cnt_q, cnt_n;
    logic              req_ready_q, req_ready_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_n;
    logic              ram_we_q, ram_we_n;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_n;
    logic [DATA_W-1:0] ram_din_q, ram_din_n;
    logic              busy_q, busy_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            req_ready_q <= req_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            ram_we_q    <= ram_we_n;
            ram_addr_q  <= ram_addr_n;
            ram_din_q   <= ram_din_n;
            busy_q      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        rsp_valid_n = rsp_valid_q;
        rsp_rdata_n = rsp_rdata_q;
        // write enable is a one-cycle pulse, only raised on entry to WRITE
        ram_we_n    = 1'b0;
        ram_addr_n  = ram_addr_q;
        ram_din_n   = ram_din_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    ram_addr_n = bus.req_addr;
                    ram_din_n  = bus.req_wdata;
                    cnt_n      = 2'd0;
                    if (bus.req_we) begin
                        state_n  = WRITE;
                        ram_we_n = 1'b1;
                    end else begin
                        state_n  = READ;
                    end
                end
            end
            WRITE: begin
                // RAM captures the write on the edge that leaves this state
                state_n = IDLE;
            end
            READ: begin
                if (cnt_q == LAT_CNT) begin
                    rsp_rdata_n = ram_q;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        req_ready_n = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_data_in   = ram_din_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - scoreboard bench for ram_access_ctrl with RD_LAT 1 and 2 RAMs
module tb_ram_access_ctrl;
    import ram_if_pkg::*;

    localparam int AW = 6;
    localparam int DW = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    logic [DW-1:0] ram1_din, ram1_q, ram2_din, ram2_q;
    logic [AW-1:0] ram1_addr, ram2_addr;
    logic          ram1_we, ram2_we, busy1, busy2;

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1),
        .ram_data_in(ram1_din), .ram_addr(ram1_addr), .ram_we(ram1_we),
        .ram_q(ram1_q), .busy(busy1)
    );
    single_port_RAM #(.ADDR_W(AW), .DATA_W(DW), .LAT(1)) ram1 (
        .clk(clock), .we(ram1_we), .addr(ram1_addr), .data_in(ram1_din), .q(ram1_q)
    );

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2),
        .ram_data_in(ram2_din), .ram_addr(ram2_addr), .ram_we(ram2_we),
        .ram_q(ram2_q), .busy(busy2)
    );
    single_port_RAM #(.ADDR_W(AW), .DATA_W(DW), .LAT(2)) ram2 (
        .clk(clock), .we(ram2_we), .addr(ram2_addr), .data_in(ram2_din), .q(ram2_q)
    );

    // reference model: plain memory image plus knowledge of which words are defined
    logic [DW-1:0] model_mem [64];
    bit            known     [64];

    typedef struct {
        logic [DW-1:0] data;
        int            hs;
        bit            known;
    } exp_t;
    exp_t exp1[$];
    exp_t exp2[$];

    int  we_cnt1  = 0;
    int  rsp_hs1  = 0;
    bit  prev_v1  = 1'b0;
    bit  rand_rdy = 1'b0;
    logic rdy_dir = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // response-ready driver, updated shortly after each rising edge
    always @(posedge clock) begin
        #2;
        bus1.rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_dir;
    end

    // monitor / scoreboard for the RD_LAT=1 controller
    always @(negedge clock) begin
        if (reset_n) begin
            if (ram1_we) we_cnt1++;
            chk("we_while_rsp_valid", int'(ram1_we & bus1.rsp_valid), 0);
            if (bus1.rsp_valid) begin
                chk("rsp_pending", int'(exp1.size() > 0), 1);
                if (exp1.size() > 0) begin
                    if (!prev_v1) chk("rsp_latency", cyc - exp1[0].hs, 2);
                    if (exp1[0].known) chk("rsp_rdata", int'(bus1.rsp_rdata), int'(exp1[0].data));
                    chk("req_ready_in_resp", int'(bus1.req_ready), 0);
                    if (bus1.rsp_ready) begin
                        void'(exp1.pop_front());
                        rsp_hs1++;
                    end
                end
            end
            prev_v1 = bus1.rsp_valid;
        end else begin
            prev_v1 = 1'b0;
        end
    end

    // monitor / scoreboard for the RD_LAT=2 controller
    always @(negedge clock) begin
        if (reset_n && bus2.rsp_valid) begin
            chk("d2_rsp_pending", int'(exp2.size() > 0), 1);
            if (exp2.size() > 0) begin
                chk("d2_rsp_latency", cyc - exp2[0].hs, 3);
                chk("d2_rsp_rdata", int'(bus2.rsp_rdata), int'(exp2[0].data));
                if (bus2.rsp_ready) void'(exp2.pop_front());
            end
        end
    end

    // issue one request on bus1; returns #1 after the handshake edge
    task automatic req1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        bus1.req_valid = 1'b1;
        bus1.req_we    = we;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        @(negedge clock);
        while (!bus1.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("req_accept_timeout", int'(n < 100), 1);
        @(posedge clock);
        #1;
        // scramble the payload afterwards; the controller must ignore it
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'($urandom);
        bus1.req_addr  = AW'($urandom);
        bus1.req_wdata = DW'($urandom);
        if (we) begin
            model_mem[a] = d;
            known[a]     = 1'b1;
        end else begin
            exp1.push_back('{data: model_mem[a], hs: cyc, known: known[a]});
        end
        chk("ram_addr_latched", int'(ram1_addr), int'(a));
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1(1'b1, a, d);
        chk("wr_we_high", int'(ram1_we), 1);
        chk("wr_data_latched", int'(ram1_din), int'(d));
        chk("wr_req_ready_low", int'(bus1.req_ready), 0);
        @(posedge clock);
        #1;
        chk("wr_we_low_after", int'(ram1_we), 0);
        chk("wr_req_ready_back", int'(bus1.req_ready), 1);
        chk("wr_addr_held", int'(ram1_addr), int'(a));
    endtask

    task automatic drain1();
        int n;
        n = 0;
        while (exp1.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("drain_timeout", int'(n < 300), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_we;
        int base_hs;
        int n;
        ram_req_t r;

        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus1.rsp_ready = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) known[i] = 1'b0;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", int'(bus1.req_ready), 1);
        chk("rst_rsp_valid", int'(bus1.rsp_valid), 0);
        chk("rst_rsp_rdata", int'(bus1.rsp_rdata), 0);
        chk("rst_ram_we", int'(ram1_we), 0);
        chk("rst_ram_addr", int'(ram1_addr), 0);
        chk("rst_ram_din", int'(ram1_din), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_d2_req_ready", int'(bus2.req_ready), 1);
        chk("rst_d2_busy", int'(busy2), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // fill the whole memory so every later read has a defined answer
        for (int i = 0; i < 64; i++) wr1(AW'(i), DW'($urandom));

        // write sequence
        base_we = we_cnt1;
        base_hs = rsp_hs1;
        wr1(6'd0, 8'h01);
        wr1(6'd1, 8'h02);
        wr1(6'd2, 8'h03);
        @(posedge clock);
        #1;
        chk("we_pulses_3_writes", we_cnt1 - base_we, 3);
        chk("no_rsp_for_writes", rsp_hs1 - base_hs, 0);

        // readback
        for (int i = 0; i < 3; i++) begin
            req1(1'b0, AW'(i), 8'h00);
            drain1();
        end

        // overwrite, then neighbouring word unchanged; back-to-back same address
        wr1(6'd1, 8'h04);
        req1(1'b0, 6'd1, 8'h00);
        drain1();
        req1(1'b0, 6'd0, 8'h00);
        req1(1'b0, 6'd0, 8'h00);
        drain1();

        // backpressure: response held for 5 cycles
        rdy_dir = 1'b0;
        @(posedge clock);
        #3;
        base_hs = rsp_hs1;
        req1(1'b0, 6'd2, 8'h00);
        n = 0;
        while (!bus1.rsp_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("bp_rsp_seen", int'(n < 10), 1);
        repeat (5) begin
            @(negedge clock);
            chk("bp_valid_held", int'(bus1.rsp_valid), 1);
            chk("bp_rdata_held", int'(bus1.rsp_rdata), 8'h03);
            chk("bp_req_ready_low", int'(bus1.req_ready), 0);
        end
        rdy_dir = 1'b1;
        drain1();
        @(posedge clock);
        #1;
        chk("bp_single_handshake", rsp_hs1 - base_hs, 1);
        chk("bp_valid_cleared", int'(bus1.rsp_valid), 0);

        // reset in the middle of a write
        req1(1'b1, 6'd10, 8'h5A);
        known[10] = 1'b0;
        chk("mid_write_we_high", int'(ram1_we), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_we_drop", int'(ram1_we), 0);
        chk("async_busy_drop", int'(busy1), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_req_ready", int'(bus1.req_ready), 1);
        chk("post_rst_rsp_valid", int'(bus1.rsp_valid), 0);
        req1(1'b0, 6'd3, 8'h00);
        drain1();

        // randomized mix with random response backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 250; k++) begin
            r.we    = 1'($urandom_range(0, 2) == 0);
            r.addr  = AW'($urandom);
            r.wdata = DW'($urandom);
            if (r.we) wr1(r.addr, r.wdata);
            else      req1(1'b0, r.addr, 8'h00);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
        end
        drain1();
        rand_rdy = 1'b0;
        chk("addr63_known", int'(known[63]), 1);
        req1(1'b0, 6'd63, 8'h00);
        drain1();

        // RD_LAT=2 controller: write 0xA5@0, read it back
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 6'd0; bus2.req_wdata = 8'hA5;
        @(negedge clock);
        chk("d2_wr_ready", int'(bus2.req_ready), 1);
        @(posedge clock);
        #1;
        bus2.req_valid = 1'b0;
        chk("d2_wr_we", int'(ram2_we), 1);
        @(posedge clock);
        #1;
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 6'd0; bus2.req_wdata = 8'h00;
        @(negedge clock);
        chk("d2_rd_ready", int'(bus2.req_ready), 1);
        @(posedge clock);
        #1;
        bus2.req_valid = 1'b0;
        exp2.push_back('{data: 8'hA5, hs: cyc, known: 1'b1});
        n = 0;
        while (exp2.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("d2_rsp_timeout", int'(n < 20), 1);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
